buffer_multi_write_controller: RTL
==================================

// Module: buffer_multi_write_controller
// PURPOSE
//  Parametrised successor of the single-channel buffer write FSM. Up to CH producers
//  (PE / datapath stages) raise done with a data word. The block latches each word,
//  arbitrates round-robin and writes one word per cycle into a shared output buffer
//  whenever the buffer is ready. Per-channel stall holds each producer until its word is written.
// PARAMETERS
//  CH    4   number of producer channels (>=1)
//  DW    16  data word width
//  CNTW  16  width of the wrap-around write counter wr_count
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  done      in   CH     done[i]=1 for one cycle: din slice i valid, capture it
//  din       in   CH*DW  channel i data at din[i*DW +: DW]
//  ready     in   1      buffer can accept a word this cycle
//  wen       out  1      buffer write enable (never high while ready=0)
//  dout      out  DW     write data, valid when wen=1
//  wsel      out  clog2(CH) (min 1)  channel index of dout
//  stall     out  CH     stall[i]=1 while channel i word is pending and not being written
//  busy      out  1      any word pending
//  overrun   out  1      sticky: done on an already-pending channel that is not being written
//  wr_count  out  CNTW   total words written, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset: pending=0, FSM=IDLE, rr pointer=0, wen=0, stall=0, busy=0, overrun=0,
//   wr_count=0, dout=0, wsel=0. Reset mid-operation drops all pending words. No write is issued.
//  Capture: done[i] with pending[i]=0 stores din slice i in hold[i] and sets pending[i] next cycle.
//  FSM states: IDLE, WRITE. Registered grant g.
//   IDLE: if |pending: g <= rr_pick(pending), go to WRITE. Else stay in IDLE.
//   WRITE: wen=ready, dout=hold[g], wsel=g.
//    If ready=0: stay in WRITE and keep g. The grant is never revoked.
//    If ready=1: clear pending[g], wr_count+1, rr pointer <= g+1 mod CH.
//     If other channels are pending (pending & ~onehot(g)): g <= next rr pick and stay in WRITE.
//     Otherwise go to IDLE.
//  rr_pick: first set bit searched from the rr pointer upward, wrapping at CH.
//  stall[i] = pending[i] & ~(state==WRITE & g==i & ready). This is combinational from ready.
//  busy = |pending.
//  Latency: done at cycle t. pending is set at t+1, WRITE at t+2, and wen is at the earliest t+2.
//   Sustained throughput is 1 word/cycle while ready=1 and any channel is pending.
//  Simultaneous events:
//   - done[g] in the cycle hold[g] is written with ready=1: the new word is captured and
//     pending[g] stays 1. This is not an overrun.
//   - done[i] while pending[i]=1 and not being written: the new word is dropped, hold[i]
//     is unchanged, and overrun is set until rst.
//   - several done in one cycle: all are captured. Write order follows the rr pointer.
//  wr_count wraps from 2^CNTW-1 to 0 without a flag.
//  CH=1: rr degenerates to a single channel and behaves as the original IDLE/WRITE controller.
// STRUCTURE
//  Include file buffer_ctrl_defs.vh holds the state codes (S_IDLE=0, S_WRITE=1) and the
//   clog2 constant function. The other buffer controllers use the same file.
//  Sub-module rr_arbiter #(CH): inputs req[CH] and ptr. Outputs gnt_idx and any.
//   It is purely combinational and instantiated once.
//  The top level holds the capture registers, pending vector, FSM, counters and output muxing.
// TESTING
//  1 Reset: assert rst 3 cycles mid-traffic -> next cycle all outputs 0, no wen, wr_count=0.
//  2 Single word: CH=4, done[2]=1, din slice2=16'hA5A5, ready=1 -> wen at t+2,
//    dout=A5A5, wsel=2, stall[2]=1 at t+1 and 0 at t+2, wr_count=1, FSM back to IDLE at t+3.
//  3 Round-robin: done=4'b1111 with data 1,2,3,4, ready=1 -> 4 back-to-back wen cycles,
//    wsel 0,1,2,3. A second burst after that starts at ptr=0 -> 0,1,2,3 again.
//    Injecting done[0] alone while the pointer is at 1 -> still served.
//  4 Backpressure: done[1], ready=0 for 5 cycles -> wen=0, stall[1]=1 throughout,
//    wsel=1 held. ready=1 -> exactly one write, then stall[1]=0.
//  5 Overrun: done[3] twice 1 cycle apart with ready=0 -> overrun=1 and remains 1,
//    and the first word is the one written. done[g] on the write cycle -> no overrun,
//    and both words are written in order.
//  6 Wrap: CNTW=4, 17 writes -> wr_count=1. Compare against a scoreboard model with random
//    done/ready: no loss, no duplicates, wen never high with ready=0.

Source files
------------

// File: rtl/buffer_multi_write_controller_pkg.sv
// Shared types and helpers for the multi-channel buffer write controller.
//   state_e : IDLE/WRITE FSM codes (S_IDLE=0, S_WRITE=1), common to the buffer controllers
//   idx_w   : clog2 with a floor of 1, sizes channel-index fields
`timescale 1ns/1ps
package buffer_multi_write_controller_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  // Bits needed to index n channels; never 0 so CH=1 still has a 1-bit wsel.
  function automatic int idx_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/buffer_multi_write_controller_if.sv
// Producer/buffer bus of the multi-channel write controller.
//   master : producers + buffer side (drives done/din/ready, observes the rest)
//   slave  : controller side
//   done[CH], din[CH*DW] (channel i at din[i*DW +: DW]), ready
//   wen, dout[DW], wsel, stall[CH], busy, overrun, wr_count[CNTW]
`timescale 1ns/1ps
interface buffer_multi_write_controller_if #(
  parameter int CH   = 4,
  parameter int DW   = 16,
  parameter int CNTW = 16
);
  import buffer_multi_write_controller_pkg::*;
  localparam int SW = idx_w(CH);

  logic [CH-1:0]    done;
  logic [CH*DW-1:0] din;
  logic             ready;
  logic             wen;
  logic [DW-1:0]    dout;
  logic [SW-1:0]    wsel;
  logic [CH-1:0]    stall;
  logic             busy;
  logic             overrun;
  logic [CNTW-1:0]  wr_count;

  modport master (
    output done, din, ready,
    input  wen, dout, wsel, stall, busy, overrun, wr_count
  );

  modport slave (
    input  done, din, ready,
    output wen, dout, wsel, stall, busy, overrun, wr_count
  );
endinterface

// File: rtl/buffer_multi_write_controller_rr_arbiter.sv
// Combinational round-robin picker.
//   req[CH] : request vector
//   ptr     : channel with highest priority; search runs upward and wraps at CH
//   gnt_idx : index of the first set request at or after ptr (0 when none)
//   any     : at least one request set
`timescale 1ns/1ps
module buffer_multi_write_controller_rr_arbiter
  import buffer_multi_write_controller_pkg::*;
#(
  parameter  int CH = 4,
  localparam int SW = idx_w(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (!any && req[(int'(ptr) + k) % CH]) begin
        any     = 1'b1;
        gnt_idx = SW'((int'(ptr) + k) % CH);
      end
    end
  end

endmodule

// File: rtl/buffer_multi_write_controller.sv
// Multi-channel buffer write controller: latches one word per producer, arbitrates
// round-robin and writes one word per cycle into a shared buffer while ready is high.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of buffer_multi_write_controller_if
//              done/din in, ready in; wen/dout/wsel out, stall/busy/overrun/wr_count out
`timescale 1ns/1ps
module buffer_multi_write_controller
  import buffer_multi_write_controller_pkg::*;
#(
  parameter int CH   = 4,
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst,
  buffer_multi_write_controller_if.slave bus
);

  localparam int SW = idx_w(CH);

  state_e              state, state_n;
  logic [SW-1:0]       g, g_n, g_inc, rr_ptr;
  logic [SW-1:0]       arb_ptr, arb_idx;
  logic                arb_any;
  logic [CH-1:0]       pending, arb_req, g_oh, wr_oh, take;
  logic [CH-1:0][DW-1:0] hold;
  logic                fire, overrun_q;
  logic [CNTW-1:0]     cnt;

  // A write only happens in WRITE with ready; rst masks it so the reset cycles
  // never present a write to the buffer.
  assign fire  = (state == S_WRITE) && bus.ready && !rst;
  assign g_oh  = CH'(1) << g;
  assign wr_oh = fire ? g_oh : '0;
  assign g_inc = (g == SW'(CH - 1)) ? '0 : g + 1'b1;

  // Accept a word when the slot is free or is being emptied this very cycle.
  assign take = bus.done & (~pending | wr_oh);

  // Single arbiter: in IDLE pick from rr_ptr; in WRITE pre-compute the follow-on
  // grant from the slot after g, excluding g itself.
  assign arb_req = (state == S_WRITE) ? (pending & ~g_oh) : pending;
  assign arb_ptr = (state == S_WRITE) ? g_inc : rr_ptr;

  buffer_multi_write_controller_rr_arbiter #(.CH(CH)) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      g     <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    case (state)
      S_IDLE: begin
        if (arb_any) begin
          state_n = S_WRITE;
          g_n     = arb_idx;
        end
      end
      S_WRITE: begin
        // Grant is held through backpressure; only a completed write moves it.
        if (bus.ready) begin
          if (arb_any) g_n = arb_idx;
          else         state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending <= (pending & ~wr_oh) | take;
      if (fire) begin
        cnt    <= cnt + 1'b1;
        rr_ptr <= g_inc;
      end
      if (|(bus.done & pending & ~wr_oh)) overrun_q <= 1'b1;
    end
  end

  // Data slots need no reset: pending qualifies them and dout is gated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (take[i]) hold[i] <= bus.din[i*DW +: DW];
    end
  end

  assign bus.wen      = fire;
  assign bus.dout     = (state == S_WRITE) ? hold[g] : '0;
  assign bus.wsel     = (state == S_WRITE) ? g : '0;
  assign bus.stall    = pending & ~wr_oh;
  assign bus.busy     = |pending;
  assign bus.overrun  = overrun_q;
  assign bus.wr_count = cnt;

endmodule
